ysyx_24080006_mem_arbiter: RTL and testbench

//  Shares the single pmem port between the instruction-fetch unit (IFU) and the load/store unit (LSU).

---
 rtl/ysyx_24080006_pkg.sv | 20 ++
 rtl/ysyx_24080006_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_24080006_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the pmem arbiter: FSM states, owner tag and the captured request payload.
package ysyx_24080006_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} arb_state_t;

  typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t;

  // Request as presented to pmem; held stable in S_REQ.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_24080006_mem_arbiter.sv
// Round-robin arbiter sharing one pmem port between IFU and LSU.
// One outstanding transaction, registered request capture, response timeout.
// Ports: clk/rst; ifu_req_* / ifu_rsp_* (fetch side); lsu_req_* / lsu_rsp_* (load/store side);
//        mem_req_* / mem_rsp_* (pmem wrapper side). Request readies are combinational grants;
//        every other output is a flop.
module ysyx_24080006_mem_arbiter
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 256,
  parameter bit          RESET_PRI = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              lsu_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  arb_owner_t          last_grant_q, last_grant_d;
  mem_req_t            req_q, req_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic                ifu_rsp_err_q, ifu_rsp_err_d;
  logic                lsu_rsp_err_q, lsu_rsp_err_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                grant_ifu, grant_lsu;

  // Round-robin pick: only offered in S_IDLE; contention goes to whoever did not win last.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && state_q == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_lsu = (last_grant_q == OWN_IFU);
        grant_ifu = (last_grant_q == OWN_LSU);
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    req_d           = req_q;
    timer_d         = timer_q;
    rsp_data_d      = rsp_data_q;
    ifu_rsp_valid_d = 1'b0;
    lsu_rsp_valid_d = 1'b0;
    ifu_rsp_err_d   = 1'b0;
    lsu_rsp_err_d   = 1'b0;
    mem_req_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_ifu) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          req_d.addr   = ifu_req_addr;
          req_d.wen    = 1'b0;
          req_d.wdata  = '0;
          req_d.wmask  = '0;
          // Misaligned fetch never reaches pmem; answer with an error directly.
          if (ifu_req_addr[1:0] != 2'b00) begin
            state_d         = S_RESP;
            rsp_data_d      = '0;
            ifu_rsp_valid_d = 1'b1;
            ifu_rsp_err_d   = 1'b1;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
          end
        end else if (grant_lsu) begin
          owner_d         = OWN_LSU;
          last_grant_d    = OWN_LSU;
          req_d.addr      = lsu_req_addr;
          req_d.wen       = lsu_req_wen;
          req_d.wdata     = lsu_req_wdata;
          req_d.wmask     = lsu_req_wmask;
          state_d         = S_REQ;
          mem_req_valid_d = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          mem_req_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (timer_q != TIMER_MAX) timer_d = timer_q + TIMER_W'(1);
        // A real response takes priority over a coincident timeout.
        if (mem_rsp_valid || timer_q == TIMER_LAST) begin
          state_d         = S_RESP;
          rsp_data_d      = mem_rsp_valid ? mem_rsp_data : '0;
          ifu_rsp_valid_d = (owner_q == OWN_IFU);
          lsu_rsp_valid_d = (owner_q == OWN_LSU);
          ifu_rsp_err_d   = (owner_q == OWN_IFU) && !mem_rsp_valid;
          lsu_rsp_err_d   = (owner_q == OWN_LSU) && !mem_rsp_valid;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_IFU;
      last_grant_q    <= RESET_PRI ? OWN_IFU : OWN_LSU;
      req_q           <= '0;
      timer_q         <= '0;
      rsp_data_q      <= '0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      mem_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      req_q           <= req_d;
      timer_q         <= timer_d;
      rsp_data_q      <= rsp_data_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
      mem_req_valid_q <= mem_req_valid_d;
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_data  = rsp_data_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_data  = rsp_data_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wen   = req_q.wen;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wmask = req_q.wmask;

endmodule

// File: tb/tb_ysyx_24080006_mem_arbiter.sv
// Self-checking bench for ysyx_24080006_mem_arbiter: the bench plays both requesters and pmem,
// and predicts grants/responses from a round-robin model and a word-addressed memory model.
module tb_ysyx_24080006_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [7:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [7:0]  mem_req_wmask;

  int checks = 0;
  int errors = 0;

  // Model: did the LSU win the most recent grant? After reset the IFU counts as last winner.
  bit last_lsu = 1'b0;
  logic [31:0] mem [logic [29:0]];

  always #5 clk = ~clk;

  ysyx_24080006_mem_arbiter #(.TIMEOUT(TO), .RESET_PRI(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b01} ^ 32'h3c5a_0f11;
  endfunction

  // pmem_write semantics: n bytes of wdata land starting at byte lane a[1:0].
  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] n);
    logic [31:0] w;
    int lane;
    w = mem_rd(a);
    for (int i = 0; i < int'(n); i++) begin
      lane = int'(a[1:0]) + i;
      if (lane < 4) w[lane*8 +: 8] = d[i*8 +: 8];
    end
    mem[a[31:2]] = w;
  endtask

  // One arbitrated transaction, starting at a negedge with the arbiter idle.
  // rdly: cycles mem_req_ready is held low; lat: cycles in S_WAIT before mem_rsp_valid (<0: never).
  task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                        input bit we, input logic [31:0] wd, input logic [7:0] wm,
                        input int rdly, input int lat);
    bit          win_lsu, mis, exp_wen;
    logic [31:0] a, seen_addr, exp_data, drv_data;
    logic [7:0]  exp_wm;
    win_lsu = (iv && lv) ? !last_lsu : lv;
    ifu_req_valid = iv; ifu_req_addr = ia;
    lsu_req_valid = lv; lsu_req_addr = la;
    lsu_req_wen = we; lsu_req_wdata = wd; lsu_req_wmask = wm;
    #1;
    chk("ifu_req_ready", ifu_req_ready, iv && !win_lsu);
    chk("lsu_req_ready", lsu_req_ready, win_lsu);
    last_lsu = win_lsu;
    mis = !win_lsu && (ia[1:0] != 2'b00);
    a = win_lsu ? la : ia;
    exp_wen = win_lsu && we;
    exp_wm = win_lsu ? wm : 8'h00;
    tick();
    // Requests dropped and inputs scrambled: captured fields must not follow them.
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_req_addr = $urandom; lsu_req_addr = $urandom; lsu_req_wdata = $urandom;
    lsu_req_wen = ~lsu_req_wen; lsu_req_wmask = 8'($urandom);
    if (mis) begin
      chk("mis_mem_req_valid", mem_req_valid, 0);
      chk("mis_ifu_rsp_valid", ifu_rsp_valid, 1);
      chk("mis_ifu_rsp_err", ifu_rsp_err, 1);
      chk("mis_ifu_rsp_data", ifu_rsp_data, 0);
      chk("mis_lsu_rsp_valid", lsu_rsp_valid, 0);
      tick();
      chk("mis_after", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 0);
      return;
    end
    seen_addr = '0;
    for (int r = 0; r <= rdly; r++) begin
      chk("mem_req_valid", mem_req_valid, 1);
      chk("mem_req_addr", mem_req_addr, a);
      chk("mem_req_wen", mem_req_wen, exp_wen);
      chk("mem_req_wmask", mem_req_wmask, exp_wm);
      if (exp_wen) chk("mem_req_wdata", mem_req_wdata, wd);
      if (r == rdly) begin
        mem_req_ready = 1'b1;
        seen_addr = mem_req_addr;
        if (exp_wen) mem_wr(a, wd, wm);
      end
      tick();
    end
    mem_req_ready = 1'b0;
    if (lat < 0) begin
      for (int k = 0; k < int'(TO); k++) begin
        chk("to_wait_quiet", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 0);
        tick();
      end
      chk("to_owner_valid", {ifu_rsp_valid, lsu_rsp_valid}, win_lsu ? 2'b01 : 2'b10);
      chk("to_owner_err", win_lsu ? lsu_rsp_err : ifu_rsp_err, 1);
      chk("to_owner_data", win_lsu ? lsu_rsp_data : ifu_rsp_data, 0);
      // Late pmem response must be ignored.
      mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
      tick();
      chk("to_late_ignored", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 0);
      mem_rsp_valid = 1'b0;
      return;
    end
    for (int k = 0; k < lat; k++) begin
      chk("wait_quiet", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 0);
      tick();
    end
    drv_data = exp_wen ? $urandom : mem_rd(seen_addr);
    exp_data = exp_wen ? drv_data : mem_rd(a);
    mem_rsp_valid = 1'b1; mem_rsp_data = drv_data;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
    chk("rsp_valid_pair", {ifu_rsp_valid, lsu_rsp_valid}, win_lsu ? 2'b01 : 2'b10);
    chk("rsp_data", win_lsu ? lsu_rsp_data : ifu_rsp_data, exp_data);
    chk("rsp_err", win_lsu ? lsu_rsp_err : ifu_rsp_err, 0);
    tick();
    chk("rsp_single_pulse", {ifu_rsp_valid, lsu_rsp_valid}, 0);
  endtask

  initial begin
    logic [31:0] ia, la, wd;
    logic [7:0]  wm;
    bit          iv, lv, we;
    int          rdly, lat;

    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_req_addr = '0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    tick(); tick();
    chk("reset_readies", {ifu_req_ready, lsu_req_ready}, 0);
    chk("reset_valids", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 0);
    chk("reset_errs", {ifu_rsp_err, lsu_rsp_err}, 0);
    chk("reset_mem_addr", mem_req_addr, 0);
    chk("reset_rsp_data", ifu_rsp_data, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Contention three times after reset: LSU, IFU, LSU.
    do_txn(1, 1, 32'h8000_0100, 32'h8000_0200, 0, 0, 8'd4, 0, 1);
    chk("rr_first_lsu", last_lsu, 1);
    do_txn(1, 1, 32'h8000_0104, 32'h8000_0204, 0, 0, 8'd4, 0, 1);
    chk("rr_second_ifu", last_lsu, 0);
    do_txn(1, 1, 32'h8000_0108, 32'h8000_0208, 0, 0, 8'd4, 1, 0);
    chk("rr_third_lsu", last_lsu, 1);

    // IFU-only fetch, memory latency 3.
    mem[30'h2000_0000] = 32'h1234_5678;
    do_txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 3);
    // LSU store held off by mem_req_ready for 5 cycles.
    do_txn(0, 1, 0, 32'h8000_0010, 1, 32'hDEAD_BEEF, 8'd4, 5, 2);
    // Load back the stored word.
    do_txn(0, 1, 0, 32'h8000_0010, 0, 0, 8'd4, 0, 0);
    chk("store_landed", mem_rd(32'h8000_0010), 32'hDEAD_BEEF);
    // Memory never answers: timeout error.
    do_txn(0, 1, 0, 32'h8000_0020, 0, 0, 8'd4, 0, -1);
    // Misaligned fetch.
    do_txn(1, 0, 32'h8000_0002, 0, 0, 0, 0, 0, 0);

    // Reset while waiting on pmem.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0040; lsu_req_wen = 1'b0;
    #1 chk("rst_case_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0;
    chk("rst_case_req_addr", mem_req_addr, 32'h8000_0040);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2 rst = 1'b1; lsu_req_valid = 1'b1;
    #1;
    chk("async_rst_addr", mem_req_addr, 0);
    chk("async_rst_all", {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                          ifu_rsp_err, lsu_rsp_err}, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
    tick();
    chk("rst_no_pulse", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    rst = 1'b0; lsu_req_valid = 1'b0; last_lsu = 1'b0;
    tick();
    chk("stray_rsp_ignored", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 0);
    mem_rsp_valid = 1'b0;
    do_txn(0, 1, 0, 32'h8000_0044, 0, 0, 8'd4, 1, 2);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) lv = 1'b1;
      ia = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 5) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      la = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 2))
        0:       wm = 8'd1;
        1:       wm = 8'd2;
        default: wm = 8'd4;
      endcase
      rdly = int'($urandom_range(0, 3));
      lat  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      do_txn(iv, lv, ia, la, we, wd, wm, rdly, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
